// File: rtl/debounce_multi_pkg.sv
// Shared constants and helpers for the multi-channel button debouncer.
// Defaults assume a 100 MHz clock: 10 ms debounce window, 0.5 s long-press.
package debounce_multi_pkg;

  localparam int DEF_CNT_MAX  = 1000000;
  localparam int DEF_HOLD_MAX = 50000000;

  // Bits needed to represent values 0..v-1; never less than 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced button channel: 2-flop synchroniser, stability counter that
// accepts a new level after CNT_MAX stable cycles, and a long-press hold timer.
module debounce_chan
  import debounce_multi_pkg::*;
#(
  parameter int CNT_MAX  = DEF_CNT_MAX,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam int CW = clog2(CNT_MAX);
  localparam int HW = clog2(HOLD_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [HW-1:0] HOLD_TOP = HW'(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_MAX - 1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hcnt;
  logic          differ;
  logic          flip;
  logic          lvl_nxt;

  always_comb begin
    differ  = sync_p1 ^ level;
    flip    = differ && (cnt == CNT_LAST);
    lvl_nxt = level ^ flip;
  end

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Stability counter: any sample equal to level restarts the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise  <= flip & ~level;
      fall  <= flip & level;
      level <= lvl_nxt;
      if (!differ || flip) cnt <= '0;
      else                 cnt <= cnt + CNT_ONE;
    end
  end

  // Hold timer restarts on every press and saturates so hold fires only once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      hold <= 1'b0;
    end else begin
      hold <= 1'b0;
      if (!lvl_nxt || flip) begin
        hcnt <= '0;
      end else if (hcnt != HOLD_TOP) begin
        hcnt <= hcnt + HOLD_ONE;
        hold <= (hcnt == HOLD_PRE);
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// N independent debounced button channels with press/release/long-press pulses.
// Only polarity correction and per-bit wiring live at this level.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int N           = 4,
  parameter int CNT_MAX     = DEF_CNT_MAX,
  parameter int HOLD_MAX    = DEF_HOLD_MAX,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] hold
);

  logic [N-1:0] btn_pol;

  assign btn_pol = (ACTIVE_HIGH != 0) ? btn : ~btn;

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_chan #(
      .CNT_MAX (CNT_MAX),
      .HOLD_MAX(HOLD_MAX)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_pol[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .hold (hold[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed timing sequences, a table of level checks
// and randomized stimulus against a window/timestamp reference model.
module tb_debounce_multi;

  localparam int N  = 4;
  localparam int CM = 4;
  localparam int HM = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn, btn_n;
  logic [N-1:0] level, rise, fall, hold;
  logic [N-1:0] level_n, rise_n, fall_n, hold_n;

  always #5 clk = ~clk;

  debounce_multi #(.N(N), .CNT_MAX(CM), .HOLD_MAX(HM), .ACTIVE_HIGH(1)) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .level(level), .rise(rise), .fall(fall), .hold(hold)
  );

  debounce_multi #(.N(N), .CNT_MAX(CM), .HOLD_MAX(HM), .ACTIVE_HIGH(0)) dut_n (
    .clk(clk), .rst(rst), .btn(btn_n),
    .level(level_n), .rise(rise_n), .fall(fall_n), .hold(hold_n)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a level flips once the last CM synchronised samples all
  // disagree with it and at least CM edges have passed since the last flip or
  // reset; hold fires exactly HM edges after the press edge if still pressed.
  int           t = 0;
  bit           m_s1  [2][N];
  bit           m_s2  [2][N];
  bit           m_lvl [2][N];
  int           m_clr [2][N];
  int           m_rt  [2][N];
  bit           hist  [2][N][CM];
  logic [N-1:0] e_lvl [2];
  logic [N-1:0] e_rise[2];
  logic [N-1:0] e_fall[2];
  logic [N-1:0] e_hold[2];

  task automatic model_edge();
    bit raw, seen, ok;
    t++;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < N; c++) begin
        raw = (i == 0) ? btn[c] : ~btn_n[c];
        e_rise[i][c] = 1'b0;
        e_fall[i][c] = 1'b0;
        e_hold[i][c] = 1'b0;
        if (rst) begin
          m_s1[i][c]  = 1'b0;
          m_s2[i][c]  = 1'b0;
          m_lvl[i][c] = 1'b0;
          m_clr[i][c] = t;
          m_rt[i][c]  = -1000;
        end else begin
          seen = m_s2[i][c];
          m_s2[i][c] = m_s1[i][c];
          m_s1[i][c] = raw;
          for (int j = CM - 1; j > 0; j--) hist[i][c][j] = hist[i][c][j-1];
          hist[i][c][0] = seen;
          ok = (t - m_clr[i][c]) >= CM;
          for (int j = 0; j < CM; j++) if (hist[i][c][j] == m_lvl[i][c]) ok = 1'b0;
          if (ok) begin
            m_lvl[i][c] = !m_lvl[i][c];
            m_clr[i][c] = t;
            if (m_lvl[i][c]) begin
              e_rise[i][c] = 1'b1;
              m_rt[i][c]   = t;
            end else begin
              e_fall[i][c] = 1'b1;
            end
          end
          e_hold[i][c] = m_lvl[i][c] && !e_rise[i][c] && ((t - m_rt[i][c]) == HM);
        end
        e_lvl[i][c] = m_lvl[i][c];
      end
    end
  endtask

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%b want=%b", nm, t, act, exp);
    end
  endtask

  task automatic check_all();
    chk("level",   level,   e_lvl[0]);
    chk("rise",    rise,    e_rise[0]);
    chk("fall",    fall,    e_fall[0]);
    chk("hold",    hold,    e_hold[0]);
    chk("level_n", level_n, e_lvl[1]);
    chk("rise_n",  rise_n,  e_rise[1]);
    chk("fall_n",  fall_n,  e_fall[1]);
    chk("hold_n",  hold_n,  e_hold[1]);
  endtask

  // Inputs are driven at the falling edge; outputs checked 1 time unit after rising
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0] b;
    int           n;
    logic [N-1:0] lv;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'b0000, 8,  4'b0000};
    tbl[1] = '{4'b0001, 8,  4'b0001};
    tbl[2] = '{4'b0011, 3,  4'b0001};
    tbl[3] = '{4'b0011, 5,  4'b0011};
    tbl[4] = '{4'b0111, 3,  4'b0011};
    tbl[5] = '{4'b0011, 8,  4'b0011};
    tbl[6] = '{4'b1100, 8,  4'b1100};
    tbl[7] = '{4'b1100, 12, 4'b1100};
    tbl[8] = '{4'b0000, 8,  4'b0000};

    rst   = 1'b1;
    btn   = '0;
    btn_n = '1;
    @(negedge clk);
    step();
    step();
    chk("reset_level", level, 4'b0000);
    rst = 1'b0;

    // Single clean press on channel 0
    btn = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("press0_rise", rise, (k == 6) ? 4'b0001 : 4'b0000);
      chk("press0_level", level, (k >= 6) ? 4'b0001 : 4'b0000);
    end
    btn = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("release0_fall", fall, (k == 6) ? 4'b0001 : 4'b0000);
      chk("release0_hold", hold, 4'b0000);
    end

    // Bouncing channel 1: 2-cycle pulses must be ignored
    for (int k = 0; k < 8; k++) begin
      btn = ((k % 4) < 2) ? 4'b0010 : 4'b0000;
      step();
      chk("bounce_rise", rise, 4'b0000);
    end
    btn = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("bounce_final_rise", rise, (k == 6) ? 4'b0010 : 4'b0000);
    end

    // Long press on channel 2: one hold pulse, then a single fall on release
    btn = 4'b0100;
    for (int k = 1; k <= 24; k++) begin
      step();
      chk("long_rise", rise, (k == 6) ? 4'b0100 : 4'b0000);
      chk("long_hold", hold, (k == 16) ? 4'b0100 : 4'b0000);
    end
    btn = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("long_fall", fall, (k == 6) ? 4'b0100 : 4'b0000);
      chk("long_hold_after", hold, 4'b0000);
    end

    // Simultaneous presses on channels 3 and 0
    btn = 4'b1001;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("simul_rise", rise, (k == 6) ? 4'b1001 : 4'b0000);
    end

    // Reset mid-count on channel 0 while channel 3 is pressed
    btn = 4'b1000;
    for (int k = 1; k <= 8; k++) step();
    btn = 4'b1001;
    for (int k = 1; k <= 4; k++) step();
    rst = 1'b1;
    #1;
    chk("async_rst_level", level, 4'b0000);
    chk("async_rst_rise",  rise,  4'b0000);
    chk("async_rst_fall",  fall,  4'b0000);
    chk("async_rst_hold",  hold,  4'b0000);
    step();
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("post_rst_rise", rise, (k == 6) ? 4'b1001 : 4'b0000);
    end

    // Active-low instance: driving channel 0 low is a press
    btn_n = 4'b1110;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("actlow_rise", rise_n, (k == 6) ? 4'b0001 : 4'b0000);
      chk("actlow_level", level_n, (k >= 6) ? 4'b0001 : 4'b0000);
    end

    // Table of held patterns and the level they settle to
    for (int v = 0; v < 9; v++) begin
      btn = tbl[v].b;
      for (int k = 0; k < tbl[v].n; k++) step();
      chk("table_level", level, tbl[v].lv);
    end

    // Randomized stimulus with alternating bouncy and calm phases
    for (int k = 0; k < 3000; k++) begin
      int div;
      div = ((k / 200) % 2 == 0) ? 3 : 20;
      rst = ($urandom_range(399) == 0);
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(div - 1) == 0) btn[c]   = ~btn[c];
        if ($urandom_range(div - 1) == 0) btn_n[c] = ~btn_n[c];
      end
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter N, default 4: number of independent button channels (1..32).
REQ-002 Parameter CNT_MAX, default 1000000: consecutive stable cycles required to accept a new level (>=2).
REQ-003 Parameter HOLD_MAX, default 50000000: cycles a channel must stay pressed before a long-press pulse (>CNT_MAX).
REQ-004 Parameter ACTIVE_HIGH, default 1: 1 = raw input high means pressed; 0 = raw input is inverted before synchronisation.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 btn  input  N  raw, asynchronous button inputs, one bit per channel.
REQ-008 level  output  N  debounced pressed state per channel (1 = pressed).
REQ-009 rise  output  N  one-cycle pulse when level goes 0->1.
REQ-010 fall  output  N  one-cycle pulse when level goes 1->0.
REQ-011 hold  output  N  one-cycle pulse when a channel has been continuously pressed for HOLD_MAX cycles.

Function
REQ-012 Each channel SHALL pass its polarity-corrected input through a 2-flop synchroniser before any other logic.
REQ-013 Each channel SHALL keep a stability counter of width clog2(CNT_MAX); it SHALL clear to 0 on every cycle the synchronised input equals level.
REQ-014 While the synchronised input differs from level, the counter SHALL increment by 1 per cycle; a bounce back to level clears it.
REQ-015 On a cycle where the input differs and the counter equals CNT_MAX-1, level SHALL toggle, the counter SHALL clear, and rise or fall SHALL assert in that same cycle.
REQ-016 Latency: a clean input change SHALL appear on level on the (CNT_MAX+2)th rising edge after the change, counting the first sampling edge as 1.
REQ-017 A pulse shorter than CNT_MAX cycles after synchronisation SHALL produce no change on level, rise or fall.
REQ-018 Each channel SHALL keep a hold counter of width clog2(HOLD_MAX+1), cleared when level is 0 and on the rise cycle.
REQ-019 While level is 1, the hold counter SHALL increment until it saturates at HOLD_MAX; hold SHALL pulse exactly once, on the cycle the counter reaches HOLD_MAX.
REQ-020 A release before HOLD_MAX SHALL produce fall and no hold; re-arming of hold SHALL require a new rise.
REQ-021 rise, fall and hold SHALL be registered outputs, high for exactly one cycle per event; rise and fall SHALL never both be high on one channel.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be reported in the same cycle.

Reset
REQ-023 Asserting rst SHALL immediately clear synchronisers, all counters, level, rise, fall and hold to 0, regardless of clk.
REQ-024 A button held through reset release SHALL be reported as a normal press: rise after CNT_MAX+2 edges, hold after a further HOLD_MAX cycles.
REQ-025 Reset asserted mid-count SHALL discard the partial count with no output pulse.

Structure
REQ-026 A shared header/package SHALL hold the clog2 constant function and the default CNT_MAX and HOLD_MAX values (100 MHz timing).
REQ-027 One sub-module, debounce_chan (synchroniser, stability counter, hold counter for one bit), SHALL be instantiated N times via generate.
REQ-028 Top-level logic SHALL be limited to polarity inversion and bit-slice wiring.

Verification (N=4, CNT_MAX=4, HOLD_MAX=10, ACTIVE_HIGH=1 unless stated)
REQ-029 btn[0] 0->1 held -> level[0]=1 and rise[0]=1 for one cycle exactly 6 edges after the change; other channels stay 0.
REQ-030 btn[1] toggled 1,0,1,0 with 2-cycle high pulses, then held 1 -> no rise during bouncing; a single rise 6 edges after the final stable 1.
REQ-031 btn[2] held 1 for 20 cycles -> rise, then one hold pulse 10 cycles later, no repeat; release -> one fall 6 edges later.
REQ-032 btn[3] and btn[0] pressed on the same edge -> rise[3] and rise[0] asserted in the same cycle.
REQ-033 rst pulsed mid-count (counter=2) while btn[0]=1 -> all outputs 0 immediately; rise[0] 6 edges after rst deasserts.
REQ-034 ACTIVE_HIGH=0, btn=4'hF idle, btn[0] driven 0 -> level[0]=1 and rise[0] after 6 edges.
